rank_insert_arbiter: RTL
========================

Name: rank_insert_arbiter

Overview:
- Shares one rank computation block (insert/busy/flowID/meta in; valid/rank/meta/remove out) among NUM_REQ ingress requesters.
- Round-robin grant with bounded burst per grant. Out-of-range flow IDs are dropped before they reach the rank block.
- Forwards the rank block's fall-through output to the PIFO stage through a valid/ready handshake and issues its remove strobe.
- Sits between the per-port descriptor queues and the rank pipe.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- FLOW_ID_WIDTH, 16, flow ID width
- META_WIDTH, 16, metadata width
- RANK_WIDTH, 16, rank width
- MAX_NUM_FLOWS, 4, flow IDs >= this are dropped
- BURST_LEN, 4, max consecutive accepts per grant (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester valid
- req_ready  out  NUM_REQ  per-requester ready
- req_flow_id  in  NUM_REQ*FLOW_ID_WIDTH  flattened flow IDs; requester i at slice i
- req_meta  in  NUM_REQ*META_WIDTH  flattened metadata
- rank_busy  in  1  rank block nearly full
- rank_insert  out  1  insert strobe to rank block
- rank_flow_id  out  FLOW_ID_WIDTH  flow ID to rank block
- rank_meta  out  META_WIDTH  metadata to rank block
- rank_valid  in  1  rank block head valid
- rank_rank  in  RANK_WIDTH  head rank
- rank_meta_in  in  META_WIDTH  head metadata
- rank_remove  out  1  pop rank block head
- out_valid  out  1  ranked descriptor valid to PIFO
- out_ready  in  1  PIFO accepts
- out_rank  out  RANK_WIDTH  rank to PIFO
- out_meta  out  META_WIDTH  metadata to PIFO
- drop_cnt  out  16  saturating count of dropped invalid-flow requests
- stat_accept_cnt  out  NUM_REQ*32  per-requester accept counters (optional feature)

Behaviour:
- Reset state:
  - state=IDLE, grant=0, rr_ptr=0, burst_cnt=0, drop_cnt=0.
  - req_ready=0 and rank_insert=0. rank_remove/out_valid follow rank_valid, which is 0 from a reset rank block.
- FSM states: IDLE, SERVE.
- IDLE:
  - If any req_valid, grant <= first requester at or after rr_ptr, scanning upward with wrap.
  - burst_cnt <= 0; next state SERVE.
  - Otherwise stay in IDLE. The arbitration bubble is exactly 1 cycle.
- SERVE:
  - req_ready[grant] = !rank_busy. All other req_ready bits are 0.
  - Accept = req_valid[grant] && req_ready[grant].
  - On accept with req_flow_id < MAX_NUM_FLOWS: rank_insert=1 in the same cycle (combinational). rank_flow_id/rank_meta come from the granted slice.
  - On accept with req_flow_id >= MAX_NUM_FLOWS: request is consumed, rank_insert=0, drop_cnt increments (saturates at 0xFFFF).
  - Each accept increments burst_cnt.
  - Leave to IDLE, with rr_ptr <= (grant+1) mod NUM_REQ, when either:
    - an accept occurs with burst_cnt==BURST_LEN-1, or
    - req_valid[grant]==0.
  - rank_busy=1 holds SERVE without counting and without leaving.
- rank_insert is never asserted while rank_busy=1, or in IDLE.
- Output side (purely combinational, zero latency):
  - out_valid=rank_valid; out_rank=rank_rank; out_meta=rank_meta_in.
  - rank_remove = rank_valid && out_ready.
- Insert and remove may occur in the same cycle. They are independent.
- Simultaneous requests: the lowest index at or after rr_ptr wins. After a grant ends, rr_ptr moves past that requester, so no starvation.
- rst asserted mid-burst: all state returns to reset values next edge. Any in-flight accept that cycle is not counted.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined: stat_accept_cnt holds one 32-bit wrapping counter per requester. Each increments on every accept, valid or dropped. All reset to 0.
- Undefined: the counters are not instantiated and stat_accept_cnt is driven constant 0.

Decomposition:
- Package rank_arb_pkg:
  - FSM state encoding (IDLE=0, SERVE=1)
  - index-width constant/function (clog2 of NUM_REQ)
  - DROP_CNT_WIDTH=16, STAT_CNT_WIDTH=32
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: found flag, index.
  - Instantiated once in the IDLE grant path.

Test Plan:
- Req0 only valid with 6 descriptors, flow IDs 0..3, rank_busy=0 -> IDLE bubble, 4 inserts on 4 consecutive cycles, IDLE bubble, 2 more inserts; rr_ptr=1 after first burst.
- req_valid=4'b1111 continuously, BURST_LEN=4 -> grants cycle 0,1,2,3,0 with 4 inserts each, 1 idle cycle between bursts; no requester starves.
- Req2 valid, flow ID 7 (>=4) -> req_ready[2]=1, rank_insert=0, drop_cnt 0->1; next descriptor with flow ID 1 is inserted normally.
- rank_busy=1 for 3 cycles mid-burst after 2 accepts -> req_ready=0, rank_insert=0 for those cycles; burst resumes and completes 2 more accepts, then the grant ends.
- rank_valid=1 with rank 0x0005, out_ready toggling 0,1,1 -> rank_remove=0,1,1, matching out_valid&&out_ready; out_rank tracks rank_rank each cycle.
- With ARB_STATS_EN, 5 accepts on req1 then rst for 1 cycle -> stat_accept_cnt[1] reads 5, then 0; state IDLE, drop_cnt 0.

Source files
------------

// File: rtl/rank_arb_pkg.sv
// Shared types and constants for the rank insert arbiter.
package rank_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    localparam int DROP_CNT_WIDTH = 16;
    localparam int STAT_CNT_WIDTH = 32;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit at or after ptr, wrapping upward.
module rr_pick
    import rank_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int c;

    // Scan from the farthest offset down so the nearest candidate wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (req[c]) begin
                found = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/rank_insert_arbiter.sv
// Round-robin arbiter feeding one shared rank block, with zero-latency PIFO forwarding.
// Optional per-requester accept counters are built when ARB_STATS_EN is defined.
module rank_insert_arbiter
    import rank_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int FLOW_ID_WIDTH = 16,
    parameter int META_WIDTH    = 16,
    parameter int RANK_WIDTH    = 16,
    parameter int MAX_NUM_FLOWS = 4,
    parameter int BURST_LEN     = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*FLOW_ID_WIDTH-1:0]    req_flow_id,
    input  logic [NUM_REQ*META_WIDTH-1:0]       req_meta,
    input  logic                                rank_busy,
    output logic                                rank_insert,
    output logic [FLOW_ID_WIDTH-1:0]            rank_flow_id,
    output logic [META_WIDTH-1:0]               rank_meta,
    input  logic                                rank_valid,
    input  logic [RANK_WIDTH-1:0]               rank_rank,
    input  logic [META_WIDTH-1:0]               rank_meta_in,
    output logic                                rank_remove,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [RANK_WIDTH-1:0]               out_rank,
    output logic [META_WIDTH-1:0]               out_meta,
    output logic [DROP_CNT_WIDTH-1:0]           drop_cnt,
    output logic [NUM_REQ*STAT_CNT_WIDTH-1:0]   stat_accept_cnt
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int BW = idx_w(BURST_LEN);

    arb_state_t          state, state_n;
    logic [IW-1:0]       grant, rr_ptr, grant_inc, pick_idx;
    logic [BW-1:0]       burst_cnt;
    logic                pick_found, accept, flow_ok, leave;
    logic [FLOW_ID_WIDTH-1:0] flow_arr [NUM_REQ];
    logic [META_WIDTH-1:0]    meta_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign flow_arr[g] = req_flow_id[g*FLOW_ID_WIDTH +: FLOW_ID_WIDTH];
        assign meta_arr[g] = req_meta[g*META_WIDTH +: META_WIDTH];
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign rank_flow_id = flow_arr[grant];
    assign rank_meta    = meta_arr[grant];
    assign flow_ok      = rank_flow_id < FLOW_ID_WIDTH'(MAX_NUM_FLOWS);
    assign grant_inc    = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    assign rank_insert  = accept && flow_ok;

    // A busy rank block freezes the grant: no counting and no release.
    always_comb begin
        state_n   = state;
        req_ready = '0;
        accept    = 1'b0;
        leave     = 1'b0;
        case (state)
            IDLE: if (pick_found) state_n = SERVE;
            SERVE: begin
                req_ready[grant] = !rank_busy;
                accept = req_valid[grant] && !rank_busy;
                leave  = !rank_busy && (!req_valid[grant] ||
                         (accept && burst_cnt == BW'(BURST_LEN - 1)));
                if (leave) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                burst_cnt <= '0;
                if (pick_found) grant <= pick_idx;
            end
            if (accept) burst_cnt <= burst_cnt + 1'b1;
            if (leave) rr_ptr <= grant_inc;
            if (accept && !flow_ok && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign out_valid   = rank_valid;
    assign out_rank    = rank_rank;
    assign out_meta    = rank_meta_in;
    assign rank_remove = rank_valid && out_ready;

`ifdef ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_CNT_WIDTH-1:0] stat_q;

    // Dropped requests count too: they were still accepted from the requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (accept && grant == IW'(i)) stat_q[i] <= stat_q[i] + 1'b1;
        end
    end

    assign stat_accept_cnt = stat_q;
`else
    assign stat_accept_cnt = '0;
`endif

endmodule
